// File: rtl/m_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: IF/ID/EX/MEM/WB sequencing, format decode, halt, retire count.
// Latency: 4 cycles for ALU/branch/jump/U-type/store, 5 for loads, +1 per memory wait cycle.
// Backpressure: waits indefinitely for imem ack, up to MAX_WAIT cycles for dmem ack, then halts.
module m_multicycle_ctrl #(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic [31:0] w_ir,
    input  logic        w_imem_ack,
    input  logic        w_dmem_ack,
    input  logic        w_taken,
    output logic        w_fetch_req,
    output logic        w_ir_we,
    output logic        w_pc_we,
    output logic        w_pc_sel,
    output logic        w_dmem_re,
    output logic        w_dmem_we,
    output logic        w_rf_we,
    output logic [5:0]  w_itype,
    output logic        w_retire,
    output logic        w_halt,
    output logic [1:0]  w_cause,
    output logic [31:0] w_instret
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic [4:0] opc;
    logic       is_r, is_i, is_s, is_b, is_u, is_j;
    logic       is_load, is_sys, is_jalr, rd_zero;
    logic       ir_unused;

    assign opc     = w_ir[6:2];
    assign is_j    = (opc == 5'b11011);
    assign is_b    = (opc == 5'b11000);
    assign is_s    = (opc == 5'b01000);
    assign is_r    = (opc == 5'b01100);
    assign is_u    = (opc == 5'b01101) || (opc == 5'b00101);
    assign is_i    = !(is_j || is_b || is_s || is_r || is_u);
    assign is_load = (opc == 5'b00000);
    assign is_sys  = (opc == 5'b11100);
    assign is_jalr = (opc == 5'b11001);
    assign rd_zero = (w_ir[11:7] == 5'd0);
    assign w_itype = {is_r, is_i, is_s, is_b, is_u, is_j};

    // Upper IR bits carry immediates/funct fields that only the datapath needs.
    assign ir_unused = ^w_ir[31:12];

    // Strobes gated by reset so an aborted instruction drops them in the reset cycle.
    always_comb begin
        w_fetch_req = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_sel    = 1'b0;
        w_dmem_re   = 1'b0;
        w_dmem_we   = 1'b0;
        w_rf_we     = 1'b0;
        w_retire    = 1'b0;
        w_halt      = 1'b0;
        if (w_rst_n) begin
            case (state)
                S_IF: begin
                    w_fetch_req = 1'b1;
                    w_ir_we     = w_imem_ack;
                end
                S_MEM: begin
                    w_dmem_re = !is_s;
                    w_dmem_we = is_s;
                    if (is_s && w_dmem_ack) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end
                end
                S_WB: begin
                    w_rf_we  = !(is_s || is_b) && !rd_zero;
                    w_pc_we  = 1'b1;
                    w_pc_sel = is_j || is_jalr || (is_b && w_taken);
                    w_retire = 1'b1;
                end
                S_HALT: w_halt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state     <= S_IF;
            wait_cnt  <= '0;
            w_cause   <= 2'b00;
            w_instret <= 32'd0;
        end else begin
            if (w_retire) begin
                w_instret <= w_instret + 32'd1;
            end
            case (state)
                S_IF: begin
                    if (w_imem_ack) begin
                        state <= S_ID;
                    end
                end
                S_ID: begin
                    if (w_ir[1:0] != 2'b11) begin
                        w_cause <= 2'b01;
                        state   <= S_HALT;
                    end else begin
                        state <= S_EX;
                    end
                end
                S_EX: begin
                    if (is_sys) begin
                        w_cause <= 2'b10;
                        state   <= S_HALT;
                    end else if (is_load || is_s) begin
                        wait_cnt <= '0;
                        state    <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (w_dmem_ack) begin
                        state <= is_s ? S_IF : S_WB;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // MAX_WAIT-th unacknowledged cycle: bus timeout, nothing retires.
                        w_cause <= 2'b11;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                S_WB:    state <= S_IF;
                S_HALT:  state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

endmodule

// File: doc/m_multicycle_ctrl.md
Name: m_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- It classifies the fetched instruction into the one-hot R/I/S/B/U/J format used by the immediate generator.
- It drives the IR/PC/register-file/data-memory strobes and PC select, halts on illegal or system opcodes, and counts retired instructions.

Parameters:
- WAIT_W, 8, width of the data-memory wait counter.
- MAX_WAIT, 255, maximum cycles spent in MEM without w_dmem_ack before a bus-error halt. Must be ≤ 2^WAIT_W−1.

Ports:
- w_clk  in  1  clock; all state changes on the rising edge.
- w_rst_n  in  1  asynchronous active-low reset.
- w_ir  in  32  instruction register contents, valid from ID onward.
- w_imem_ack  in  1  instruction-memory data valid; sampled only in IF.
- w_dmem_ack  in  1  data-memory access complete; sampled only in MEM.
- w_taken  in  1  branch comparison result from the ALU; sampled only in WB.
- w_fetch_req  out  1  instruction fetch request.
- w_ir_we  out  1  instruction register load enable.
- w_pc_we  out  1  PC update enable.
- w_pc_sel  out  1  0 = PC+4, 1 = ALU target.
- w_dmem_re  out  1  data read request.
- w_dmem_we  out  1  data write request.
- w_rf_we  out  1  register-file write enable.
- w_itype  out  6  one-hot {r,i,s,b,u,j} of w_ir.
- w_retire  out  1  one-cycle pulse per completed instruction.
- w_halt  out  1  core halted (sticky).
- w_cause  out  2  halt cause: 00 none, 01 illegal, 10 system, 11 bus timeout.
- w_instret  out  32  retired-instruction count.

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT. Reset forces IF, counters to 0, w_cause to 00.
- While w_rst_n is low, every strobe, w_retire and w_halt is 0.
- Strobes are combinational from the registered state and the current inputs.
- Decode uses opc = w_ir[6:2]:
  - j: opc = 11011
  - b: opc = 11000
  - s: opc = 01000
  - r: opc = 01100
  - u: opc = 01101 or 00101
  - i: any other value
- w_itype is valid in every state and changes only when the IR changes.
- IF: w_fetch_req = 1. Wait for w_imem_ack. On the ack cycle, w_ir_we = 1 and go to ID. The fetch wait is unbounded.
- ID: if w_ir[1:0] != 11, set w_cause = 01 and go to HALT. Otherwise go to EX. ID is one cycle.
- EX, one cycle:
  - opc 11100 (system): set w_cause = 10 and go to HALT.
  - opc 00000 (load) or s-type: go to MEM.
  - otherwise: go to WB.
- MEM:
  - A load holds w_dmem_re = 1; a store holds w_dmem_we = 1, until w_dmem_ack.
  - The wait counter increments each MEM cycle without an ack.
  - When the counter reaches MAX_WAIT with no ack: set w_cause = 11 and go to HALT, with no retire.
  - Load ack: go to WB.
  - Store ack, same cycle: w_pc_we = 1, w_pc_sel = 0, w_retire = 1, then go to IF.
  - The counter clears on entry to MEM.
- WB, one cycle:
  - w_rf_we = 1 unless the instruction is s/b-type or rd (w_ir[11:7]) = 0.
  - w_pc_we = 1.
  - w_pc_sel = 1 if j-type, or opc = 11001 (jalr), or (b-type and w_taken). Otherwise 0.
  - w_retire = 1, then go to IF.
- HALT: absorbing. w_halt = 1, all strobes 0, w_cause held. Only reset leaves HALT.
- w_instret increments on every w_retire and wraps from FFFF_FFFF to 0.
- Latency with zero-wait memories:
  - ALU, branch, jump, LUI/AUIPC: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- Reset asserted mid-instruction: immediate return to IF. Pending strobes drop in the same cycle; the aborted instruction does not retire.
- Acks are ignored outside their own state, as is w_taken outside WB.

Test Plan:
- ADD x1,x2,x3 (0x003100B3), imem_ack each IF → IF,ID,EX,WB. w_itype = 100000, rf_we in WB, pc_sel = 0, retire at cycle 4, instret = 1.
- LW x5,0(x0) (0x00002283), dmem_ack after 2 wait cycles → dmem_re high for 3 cycles, rf_we in WB, retire at cycle 7.
- BEQ (0x00000063) with w_taken = 1 and then 0 → itype = 000100, rf_we = 0, pc_sel 1/0 respectively, retire each time.
- SW with dmem_ack never asserted, MAX_WAIT = 4 → HALT after 4 MEM cycles, w_cause = 11, no retire, instret unchanged.
- 0x00000000 (low bits 00) → HALT from ID, cause 01. ECALL 0x00000073 → HALT from EX, cause 10. Reset release → IF, cause 00.
- ADDI x0,x0,1 (0x00100013) → rf_we = 0, retire = 1. Reset pulsed in MEM of a load → strobes drop at once, no retire, next fetch from IF.
